// File: rtl/tl_pkg.sv
// Shared constants for the traffic-light timer scheduler.
// Owner and mode encodings plus default interval lengths.
package tl_pkg;

  localparam logic OWN_HW = 1'b0;
  localparam logic OWN_CR = 1'b1;

  localparam logic MODE_LONG  = 1'b0;
  localparam logic MODE_SHORT = 1'b1;

  localparam int TL_T_LONG_DEF  = 25;
  localparam int TL_T_SHORT_DEF = 3;

endpackage

// File: rtl/tl_down_counter.sv
// Loadable down-counter with zero flag; holds at zero unless loaded.
// Reset value is a parameter so the owner's first interval starts on reset.
module tl_down_counter #(
  parameter int              CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tl_timer_sched.sv
// Shared interval timer: grants the countdown to highway or country road.
// Optional input force_expire under `TL_FORCE_EXPIRE_EN.
module tl_timer_sched
  import tl_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int T_LONG  = TL_T_LONG_DEF,
  parameter int T_SHORT = TL_T_SHORT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hw_mode_count,
  input  logic             cr_mode_count,
  input  logic             cr_ena,
`ifdef TL_FORCE_EXPIRE_EN
  input  logic             force_expire,
`endif
  output logic             hw_time_out,
  output logic             cr_time_out,
  output logic             owner,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [CNT_W-1:0] LONG_V  = CNT_W'(T_LONG - 1);
  localparam logic [CNT_W-1:0] SHORT_V = CNT_W'(T_SHORT - 1);

  logic owner_q, owner_d;
  logic hw_to_q, hw_to_d;
  logic cr_to_q, cr_to_d;
  logic cr_ena_q, hw_mode_q, cr_mode_q;
  logic load, zero, rise, force_w;
  logic [CNT_W-1:0] load_val, hw_len, cr_len;

`ifdef TL_FORCE_EXPIRE_EN
  assign force_w = force_expire;
`else
  assign force_w = 1'b0;
`endif

  assign hw_len = (hw_mode_count == MODE_LONG) ? LONG_V : SHORT_V;
  assign cr_len = (cr_mode_count == MODE_LONG) ? LONG_V : SHORT_V;
  assign rise   = cr_ena & ~cr_ena_q;

  always_comb begin
    owner_d  = owner_q;
    hw_to_d  = 1'b0;
    cr_to_d  = 1'b0;
    load     = 1'b0;
    load_val = hw_len;
    unique case (owner_q)
      OWN_HW: begin
        // force beats handoff, handoff beats natural expiry
        if (force_w || (zero && !rise)) begin
          hw_to_d = 1'b1;
          load    = 1'b1;
        end else if (rise) begin
          owner_d  = OWN_CR;
          load     = 1'b1;
          load_val = cr_len;
        end else if (hw_mode_count != hw_mode_q) begin
          load = 1'b1;
        end
      end
      OWN_CR: begin
        if (force_w || zero) begin
          cr_to_d = 1'b1;
          load    = 1'b1;
          if (cr_mode_count == MODE_SHORT) begin
            hw_to_d = 1'b1;
            owner_d = OWN_HW;
          end else begin
            load_val = cr_len;
          end
        end else if (cr_mode_count != cr_mode_q) begin
          load     = 1'b1;
          load_val = cr_len;
        end
      end
      default: ;
    endcase
  end

  tl_down_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (LONG_V)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (load_val),
    .cnt_o      (remaining),
    .zero_o     (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_HW;
      hw_to_q   <= 1'b0;
      cr_to_q   <= 1'b0;
      cr_ena_q  <= 1'b0;
      hw_mode_q <= 1'b0;
      cr_mode_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      hw_to_q   <= hw_to_d;
      cr_to_q   <= cr_to_d;
      cr_ena_q  <= cr_ena;
      hw_mode_q <= hw_mode_count;
      cr_mode_q <= cr_mode_count;
    end
  end

  assign owner       = owner_q;
  assign hw_time_out = hw_to_q;
  assign cr_time_out = cr_to_q;

endmodule

// File: tb/tb_tl_timer_sched.sv
// Bench for tl_timer_sched: interval model plus directed literal checks.
// Exercises force_expire too when TL_FORCE_EXPIRE_EN is defined.
module tb_tl_timer_sched;

  localparam int CNT_W   = 8;
  localparam int T_LONG  = 5;
  localparam int T_SHORT = 2;

  logic clk = 1'b0;
  logic rst, hw_mode_count, cr_mode_count, cr_ena, force_expire;
  logic hw_time_out, cr_time_out, owner;
  logic [CNT_W-1:0] remaining;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  tl_timer_sched #(
    .CNT_W   (CNT_W),
    .T_LONG  (T_LONG),
    .T_SHORT (T_SHORT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hw_mode_count (hw_mode_count),
    .cr_mode_count (cr_mode_count),
    .cr_ena        (cr_ena),
`ifdef TL_FORCE_EXPIRE_EN
    .force_expire  (force_expire),
`endif
    .hw_time_out   (hw_time_out),
    .cr_time_out   (cr_time_out),
    .owner         (owner),
    .remaining     (remaining)
  );

  logic fe_in;
`ifdef TL_FORCE_EXPIRE_EN
  assign fe_in = force_expire;
`else
  assign fe_in = 1'b0;
`endif

  // Model: cycles left before expiry, who owns the timer, last inputs seen
  int m_cnt = T_LONG - 1;
  bit m_own = 0, m_hto = 0, m_cto = 0;
  bit m_ena = 0, m_hm = 0, m_cm = 0;

  always @(posedge clk) begin
    automatic int lh   = hw_mode_count ? T_SHORT : T_LONG;
    automatic int lc   = cr_mode_count ? T_SHORT : T_LONG;
    automatic bit rise = cr_ena && !m_ena;
    automatic bit done = (m_cnt == 0) || fe_in;
    m_hto = 0;
    m_cto = 0;
    if (rst) begin
      m_own = 0;
      m_cnt = T_LONG - 1;
      m_ena = 0;
      m_hm  = 0;
      m_cm  = 0;
    end else begin
      if (!m_own) begin
        if (fe_in || (done && !rise)) begin
          m_hto = 1;
          m_cnt = lh - 1;
        end else if (rise) begin
          m_own = 1;
          m_cnt = lc - 1;
        end else if (hw_mode_count != m_hm) m_cnt = lh - 1;
        else m_cnt = m_cnt - 1;
      end else begin
        if (done) begin
          m_cto = 1;
          if (cr_mode_count) begin
            m_hto = 1;
            m_own = 0;
            m_cnt = lh - 1;
          end else m_cnt = lc - 1;
        end else if (cr_mode_count != m_cm) m_cnt = lc - 1;
        else m_cnt = m_cnt - 1;
      end
      m_ena = cr_ena;
      m_hm  = hw_mode_count;
      m_cm  = cr_mode_count;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.owner", owner, m_own);
      chk("model.remaining", remaining, m_cnt);
      chk("model.hw_time_out", hw_time_out, m_hto);
      chk("model.cr_time_out", cr_time_out, m_cto);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(input string tag, input int own, input int rem,
                     input int hto, input int cto);
    chk({tag, ".owner"}, owner, own);
    chk({tag, ".remaining"}, remaining, rem);
    chk({tag, ".hw_to"}, hw_time_out, hto);
    chk({tag, ".cr_to"}, cr_time_out, cto);
  endtask

  initial begin
    rst = 1; hw_mode_count = 0; cr_mode_count = 0;
    cr_ena = 0; force_expire = 0;
    tick(1);
    chk_en = 1;
    tick(1);
    pin("reset", 0, 4, 0, 0);
    rst = 0;
    tick(4);
    pin("hw_long_cnt", 0, 0, 0, 0);
    tick(1);
    pin("hw_long_exp", 0, 4, 1, 0);
    hw_mode_count = 1;
    tick(1);
    pin("hw_mode_chg", 0, 1, 0, 0);
    tick(2);
    pin("hw_short_exp", 0, 1, 1, 0);
    tick(2);
    pin("hw_short_exp2", 0, 1, 1, 0);
    hw_mode_count = 0;
    tick(1);
    pin("hw_back_long", 0, 4, 0, 0);
    cr_ena = 1;
    tick(1);
    pin("handoff", 1, 4, 0, 0);
    tick(4);
    pin("cr_cnt", 1, 0, 0, 0);
    tick(1);
    pin("cr_long_exp", 1, 4, 0, 1);
    cr_mode_count = 1;
    tick(1);
    pin("cr_mode_chg", 1, 1, 0, 0);
    tick(2);
    pin("cr_return", 0, 4, 1, 1);
    tick(1);
    pin("ena_held", 0, 3, 0, 0);
    cr_ena = 0; cr_mode_count = 0;
    tick(3);
    pin("pre_coinc", 0, 0, 0, 0);
    cr_ena = 1;
    tick(1);
    pin("coinc_handoff", 1, 4, 0, 0);
    cr_ena = 0;
    tick(2);
    pin("mid_count", 1, 2, 0, 0);
    rst = 1;
    tick(1);
    pin("mid_rst", 0, 4, 0, 0);
    rst = 0;
`ifdef TL_FORCE_EXPIRE_EN
    tick(1);
    pin("pre_force", 0, 3, 0, 0);
    force_expire = 1;
    tick(1);
    pin("force_exp", 0, 4, 1, 0);
    force_expire = 0;
`endif
    for (int i = 0; i < 400; i++) begin
      hw_mode_count = ($urandom_range(0, 7) == 0) ? ~hw_mode_count : hw_mode_count;
      cr_mode_count = ($urandom_range(0, 5) == 0) ? ~cr_mode_count : cr_mode_count;
      cr_ena        = ($urandom_range(0, 9) == 0) ? ~cr_ena : cr_ena;
      rst           = ($urandom_range(0, 99) == 0);
`ifdef TL_FORCE_EXPIRE_EN
      force_expire  = ($urandom_range(0, 19) == 0);
`endif
      tick(1);
    end
    rst = 0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
